// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared types, widths and event precedence for fetch_sequencer
//
// Contents:
//   FETCH_ADDR_W  default PC / ROM address width
//   state_e       sequencer states
//   event_e       same-cycle events, encoded in precedence order
//   pick_event()  resolves simultaneous events to the single winner
package fetch_seq_pkg;

    localparam int FETCH_ADDR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_ADVANCE,
        S_LOAD,
        S_PRIME,
        S_SETTLE,
        S_HALT
    } state_e;

    // Lower encoding wins. Reset is handled outside this table because it
    // overrides everything, including state-independent bookkeeping.
    typedef enum logic [2:0] {
        EV_HALT,
        EV_REDIRECT,
        EV_ACCEPT,
        EV_ACK,
        EV_NONE
    } event_e;

    // Inputs are expected to be pre-qualified by state by the caller.
    function automatic event_e pick_event(
        input logic halt,
        input logic redirect,
        input logic accept,
        input logic ack
    );
        if (halt)     return EV_HALT;
        if (redirect) return EV_REDIRECT;
        if (accept)   return EV_ACCEPT;
        if (ack)      return EV_ACK;
        return EV_NONE;
    endfunction

endpackage

// File: rtl/fetch_return_stack.sv
// rtl/fetch_return_stack.sv - small LIFO of return addresses for call/ret redirects
//
// Ports:
//   clock, reset      clock; synchronous active-low reset (empties the stack)
//   push, push_data   write push_data on top (ignored when full)
//   pop               drop the top entry (ignored when empty; push wins if both)
//   top               current top entry (meaningless when empty)
//   full, empty       occupancy flags
module fetch_return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] top_idx;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign top_idx = IDX_W'(count_q - CNT_W'(1));
    assign top     = mem_q[top_idx];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[IDX_W'(count_q)] = push_data;
            count_d                = count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC fetch/issue/advance sequencer with branch, halt and ROM timeout
//
// Optional feature macro: FETCH_SEQ_CALL_STACK_EN (adds call_valid/ret_valid
// and a return-address stack of STACK_DEPTH entries).
//
// Ports:
//   clock, reset                    clock; synchronous active-low reset
//   run                             level, 1 = start/continue execution
//   pc_value                        current PC output
//   mem_req, mem_addr               ROM request (held until ack), address = pc_value
//   mem_ack, mem_data               one-cycle ROM response
//   instr_valid, instr, instr_accept  decode handshake
//   branch_valid, branch_target     one-cycle redirect request
//   halt_req                        one-cycle stop request
//   call_valid, ret_valid           (macro only) call/return redirects
//   pc_enable, pc_inc_or_set, pc_new_value  PC write controls
//   halted, fault                   HALT state; sticky ROM-timeout / stack error
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int ADDR_W   = FETCH_ADDR_W,
    parameter int MAX_WAIT = 255
`ifdef FETCH_SEQ_CALL_STACK_EN
    ,
    parameter int STACK_DEPTH = 4
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data,
    output logic              instr_valid,
    output logic [15:0]       instr,
    input  logic              instr_accept,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt_req,
`ifdef FETCH_SEQ_CALL_STACK_EN
    input  logic              call_valid,
    input  logic              ret_valid,
`endif
    output logic              pc_enable,
    output logic              pc_inc_or_set,
    output logic [ADDR_W-1:0] pc_new_value,
    output logic              halted,
    output logic              fault
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_e            state_q, state_d;
    event_e            ev;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
    logic [15:0]       instr_q, instr_d;
    logic              mem_req_q, mem_req_d;
    logic              instr_valid_q, instr_valid_d;
    logic              pc_enable_q, pc_enable_d;
    logic              pc_inc_or_set_q, pc_inc_or_set_d;
    logic [ADDR_W-1:0] pc_new_value_q, pc_new_value_d;
    logic              halted_q, halted_d;

    logic              redirect_req;
    logic              redirect_err;
    logic [ADDR_W-1:0] redirect_target;

`ifdef FETCH_SEQ_CALL_STACK_EN
    logic              stack_push, stack_pop, stack_full, stack_empty;
    logic              call_push, ret_pop;
    logic [ADDR_W-1:0] stack_top;

    // Branch outranks call, call outranks return; only the winner touches the stack.
    assign call_push       = !branch_valid && call_valid;
    assign ret_pop         = !branch_valid && !call_valid && ret_valid;
    assign redirect_req    = branch_valid | call_valid | ret_valid;
    assign redirect_err    = (call_push && stack_full) || (ret_pop && stack_empty);
    assign redirect_target = ret_pop ? stack_top : branch_target;

    fetch_return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_return_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (pc_value + ADDR_W'(1)),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );
`else
    assign redirect_req    = branch_valid;
    assign redirect_err    = 1'b0;
    assign redirect_target = branch_target;
`endif

    always_comb begin
        state_d        = state_q;
        wait_d         = '0;
        fault_d        = fault_q;
        instr_d        = instr_q;
        pc_new_value_d = '0;
`ifdef FETCH_SEQ_CALL_STACK_EN
        stack_push     = 1'b0;
        stack_pop      = 1'b0;
`endif
        // Redirects are only honoured where a squash is meaningful; LOAD/PRIME
        // must complete as a pair so the PC output lines up with the target.
        ev = pick_event(halt_req && (state_q != S_IDLE),
                        redirect_req && (state_q inside {S_FETCH, S_ISSUE, S_SETTLE}),
                        instr_accept && (state_q == S_ISSUE),
                        mem_ack && (state_q == S_FETCH));

        case (ev)
            EV_HALT: state_d = S_HALT;
            EV_REDIRECT: begin
                if (redirect_err) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d        = S_LOAD;
                    pc_new_value_d = redirect_target;
`ifdef FETCH_SEQ_CALL_STACK_EN
                    stack_push     = call_push;
                    stack_pop      = ret_pop;
`endif
                end
            end
            EV_ACCEPT: state_d = S_ADVANCE;
            EV_ACK: begin
                state_d = S_ISSUE;
                instr_d = mem_data;
            end
            default: begin
                case (state_q)
                    S_IDLE:    if (run) state_d = S_FETCH;
                    S_FETCH: begin
                        if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                            fault_d = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            wait_d = wait_q + WAIT_W'(1);
                        end
                    end
                    S_ADVANCE: state_d = S_SETTLE;
                    S_LOAD:    state_d = S_PRIME;
                    S_PRIME:   state_d = S_SETTLE;
                    S_SETTLE:  state_d = run ? S_FETCH : S_IDLE;
                    default:   state_d = state_q;
                endcase
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // alongside it and line up with the state they describe.
        mem_req_d       = (state_d == S_FETCH);
        instr_valid_d   = (state_d == S_ISSUE);
        pc_enable_d     = (state_d inside {S_ADVANCE, S_LOAD, S_PRIME});
        pc_inc_or_set_d = (state_d == S_LOAD);
        halted_d        = (state_d == S_HALT);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            wait_q          <= '0;
            fault_q         <= 1'b0;
            instr_q         <= '0;
            mem_req_q       <= 1'b0;
            instr_valid_q   <= 1'b0;
            pc_enable_q     <= 1'b0;
            pc_inc_or_set_q <= 1'b0;
            pc_new_value_q  <= '0;
            halted_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            fault_q         <= fault_d;
            instr_q         <= instr_d;
            mem_req_q       <= mem_req_d;
            instr_valid_q   <= instr_valid_d;
            pc_enable_q     <= pc_enable_d;
            pc_inc_or_set_q <= pc_inc_or_set_d;
            pc_new_value_q  <= pc_new_value_d;
            halted_q        <= halted_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_req_q ? pc_value : '0;
    assign instr_valid   = instr_valid_q;
    assign instr         = instr_q;
    assign pc_enable     = pc_enable_q;
    assign pc_inc_or_set = pc_inc_or_set_q;
    assign pc_new_value  = pc_new_value_q;
    assign halted        = halted_q;
    assign fault         = fault_q;

endmodule
